// File: rtl/fetch_unit.sv
// fetch_unit: program counter, two-level return stack and instruction register feeding the decoder.
// Decoder phase encodings live in fetch_unit_pkg so the decoder and this stage share one definition.
package fetch_unit_pkg;
    parameter int FE_STATE_BITS = 2;
    parameter int EX_STATE_BITS = 4;

    localparam logic [FE_STATE_BITS-1:0] FE_Q1_INCPC = 2'd0;
    localparam logic [FE_STATE_BITS-1:0] FE_Q2_IDLE  = 2'd1;
    localparam logic [FE_STATE_BITS-1:0] FE_Q3_IDLE  = 2'd2;
    localparam logic [FE_STATE_BITS-1:0] FE_Q4_FETCH = 2'd3;

    // Every code above EX_Q3 is a Q4 execute state.
    localparam logic [EX_STATE_BITS-1:0] EX_Q1         = 4'd0;
    localparam logic [EX_STATE_BITS-1:0] EX_Q2         = 4'd1;
    localparam logic [EX_STATE_BITS-1:0] EX_Q3         = 4'd2;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRF    = 4'd3;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CLRW    = 4'd4;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_FSZ     = 4'd5;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVWF   = 4'd6;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_BXF     = 4'd7;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_BTFSX   = 4'd8;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_CALL    = 4'd9;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_GOTO    = 4'd10;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_RETLW   = 4'd11;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_MOVLW   = 4'd12;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_ALU     = 4'd13;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_00_ELSE = 4'd14;
    localparam logic [EX_STATE_BITS-1:0] EX_Q4_NOP     = 4'd15;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 11,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FE_STATE_BITS-1:0] fetchState,
    input  logic [EX_STATE_BITS-1:0] executeState,
    input  logic [11:0]              romData,
    input  logic                     skipReq,
    input  logic                     pclWrite,
    input  logic [7:0]               aluResult,
    input  logic [1:0]               statusPA,
    output logic [PC_WIDTH-1:0]      romAddr,
    output logic [11:0]              instOut,
    output logic [7:0]               pclOut
);
    logic [PC_WIDTH-1:0] pc, pcNext, stack0, stack0Next, stack1, stack1Next;
    logic [11:0] instReg, instNext;
    logic holdInc, holdNext, flush;
    logic exQ4, isPcl, isGoto, isCall, isRet, isSkip;
    logic [10:0] gotoFull, callFull, pclFull;

    // Targets are formed at the full 11-bit width and truncated, so unused page bits drop out.
    assign gotoFull = {statusPA, instReg[8:0]};
    assign callFull = {statusPA, 1'b0, instReg[7:0]};
    assign pclFull  = {statusPA, 1'b0, aluResult};

    assign exQ4   = executeState > EX_Q3;
    assign isPcl  = exQ4 && pclWrite;
    assign isGoto = executeState == EX_Q4_GOTO;
    assign isCall = executeState == EX_Q4_CALL;
    assign isRet  = executeState == EX_Q4_RETLW;
    assign isSkip = skipReq && (executeState == EX_Q4_FSZ || executeState == EX_Q4_BTFSX);

    always_comb begin
        pcNext     = pc;
        stack0Next = stack0;
        stack1Next = stack1;
        holdNext   = holdInc;
        flush      = 1'b0;
        if (fetchState == FE_Q1_INCPC) begin
            pcNext   = holdInc ? pc : pc + 1'b1;
            holdNext = 1'b0;
        end
        if (isPcl) begin
            pcNext   = pclFull[PC_WIDTH-1:0];
            holdNext = 1'b1;
            flush    = 1'b1;
        end else if (isGoto) begin
            pcNext   = gotoFull[PC_WIDTH-1:0];
            holdNext = 1'b1;
            flush    = 1'b1;
        end else if (isCall) begin
            stack1Next = stack0;
            stack0Next = pc;
            pcNext     = callFull[PC_WIDTH-1:0];
            holdNext   = 1'b1;
            flush      = 1'b1;
        end else if (isRet) begin
            pcNext     = stack0;
            stack0Next = stack1;
            holdNext   = 1'b1;
            flush      = 1'b1;
        end else if (isSkip) begin
            flush = 1'b1;
        end
        instNext = (fetchState == FE_Q4_FETCH) ? (flush ? 12'h000 : romData) : instReg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_VECTOR;
            instReg <= 12'h000;
            stack0  <= '0;
            stack1  <= '0;
            holdInc <= 1'b0;
        end else begin
            pc      <= pcNext;
            instReg <= instNext;
            stack0  <= stack0Next;
            stack1  <= stack1Next;
            holdInc <= holdNext;
        end
    end

    assign romAddr = pc;
    assign instOut = instReg;
    assign pclOut  = pc[7:0];
endmodule
